// File: rtl/adder_chk_pkg.sv
// Shared types and constants for the 2-bit adder response checker.
package adder_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bit positions inside the 5-bit stimulus vector {a0,a1,b0,b1,cin}
  localparam int A0_B  = 4;
  localparam int A1_B  = 3;
  localparam int B0_B  = 2;
  localparam int B1_B  = 1;
  localparam int CIN_B = 0;

  localparam int NUM_VEC_DEF = 32;

endpackage

// File: rtl/adder_golden.sv
// Combinational reference for the 2-bit ripple adder: exp_sum = a + b + cin.
module adder_golden
  import adder_chk_pkg::*;
(
  input  logic [4:0] vec,
  output logic [2:0] exp_sum
);

  logic [1:0] a;
  logic [1:0] b;
  logic       cin;

  // The vector stores the low operand bit above the high one, so reassemble MSB-first.
  assign a   = {vec[A1_B], vec[A0_B]};
  assign b   = {vec[B1_B], vec[B0_B]};
  assign cin = vec[CIN_B];

  assign exp_sum = {1'b0, a} + {1'b0, b} + {2'b00, cin};

endmodule

// File: rtl/adder_resp_checker.sv
// Samples adder outputs over a vector sweep, checks against the golden model,
// counts failures, captures the first failing vector and reports pass/fail.
module adder_resp_checker
  import adder_chk_pkg::*;
#(
  parameter int NUM_VEC = NUM_VEC_DEF,
  parameter int ERR_W   = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             vec_valid,
  input  logic [4:0]       vec,
  input  logic [1:0]       dut_s,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             mismatch,
  output logic [ERR_W-1:0] err_cnt,
  output logic             seq_err,
  output logic [4:0]       first_fail
);

  localparam logic [4:0]       LAST_IDX = 5'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [4:0]       idx_q;
  logic [2:0]       exp_sum;
  logic             sample;
  logic             arm;
  logic             fail;
  logic             last;
  logic [ERR_W-1:0] err_nxt;
  logic             seq_nxt;

  adder_golden u_golden (
    .vec     (vec),
    .exp_sum (exp_sum)
  );

  assign sample  = (state_q == RUN) && vec_valid;
  assign arm     = start && (state_q != RUN);
  assign fail    = ({dut_cout, dut_s} != exp_sum);
  assign last    = (idx_q == LAST_IDX);
  assign err_nxt = (fail && (err_cnt != ERR_MAX)) ? err_cnt + ERR_ONE : err_cnt;
  assign seq_nxt = seq_err | (vec != idx_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (sample && last) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      mismatch   <= 1'b0;
      err_cnt    <= '0;
      seq_err    <= 1'b0;
      first_fail <= '0;
      idx_q      <= '0;
    end else begin
      busy     <= (state_d == RUN);
      done     <= (state_d == DONE);
      mismatch <= sample && fail;
      if (arm) begin
        idx_q      <= '0;
        err_cnt    <= '0;
        seq_err    <= 1'b0;
        first_fail <= '0;
        pass       <= 1'b0;
      end else if (sample) begin
        idx_q   <= idx_q + 5'd1;
        err_cnt <= err_nxt;
        seq_err <= seq_nxt;
        // err_cnt still zero means no earlier failure in this sweep
        if (fail && (err_cnt == '0)) first_fail <= vec;
        if (last) pass <= (err_nxt == '0) && !seq_nxt;
      end
    end
  end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker: vector table plus hand-written sweeps.
module tb_adder_resp_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       vec_valid = 1'b0;
  logic [4:0] vec = '0;
  logic [1:0] dut_s, sat_s;
  logic       dut_cout, sat_cout;
  logic [2:0] ovr = '0;
  int         fault_mode = 0;  // 0 good, 1 S0 stuck at 0, 2 table override

  logic       busy, done, pass, mismatch, seq_err;
  logic [5:0] err_cnt;
  logic [4:0] first_fail;
  logic       s_busy, s_done, s_pass, s_mismatch, s_seq_err;
  logic [2:0] s_err_cnt;
  logic [4:0] s_first_fail;

  int n_cmp = 0;
  int n_fail = 0;
  int mm_pulses = 0;

  always #5 clk = ~clk;

  function automatic logic [2:0] ref_sum(input logic [4:0] v);
    int a, b, c;
    a = 2 * v[3] + v[4];
    b = 2 * v[1] + v[2];
    c = v[0];
    return 3'(a + b + c);
  endfunction

  logic [2:0] good;
  assign good = ref_sum(vec);
  assign {dut_cout, dut_s} = (fault_mode == 0) ? good :
                             (fault_mode == 1) ? (good & 3'b110) : ovr;
  assign {sat_cout, sat_s} = ~good;

  adder_resp_checker #(.NUM_VEC(32), .ERR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_s(dut_s), .dut_cout(dut_cout), .busy(busy), .done(done), .pass(pass),
    .mismatch(mismatch), .err_cnt(err_cnt), .seq_err(seq_err), .first_fail(first_fail)
  );

  adder_resp_checker #(.NUM_VEC(32), .ERR_W(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_valid(vec_valid), .vec(vec),
    .dut_s(sat_s), .dut_cout(sat_cout), .busy(s_busy), .done(s_done), .pass(s_pass),
    .mismatch(s_mismatch), .err_cnt(s_err_cnt), .seq_err(s_seq_err), .first_fail(s_first_fail)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle at the falling edge, let the rising edge take it, settle.
  task automatic tick(input logic st, input logic vv, input logic [4:0] v);
    @(negedge clk);
    start = st; vec_valid = vv; vec = v;
    @(posedge clk);
    #1;
    start = 1'b0; vec_valid = 1'b0;
    if (mismatch === 1'b1) mm_pulses++;
  endtask

  task automatic run_sweep(input int from);
    for (int i = from; i < 32; i++) tick(1'b0, 1'b1, 5'(i));
  endtask

  typedef struct {
    logic [4:0] v;
    logic [2:0] drv;
    logic       exp_mm;
    int         exp_err;
    logic [4:0] exp_ff;
  } row_t;

  row_t tbl[10];

  initial begin
    tbl[0] = '{5'd0, 3'd0, 1'b0, 0, 5'd0};
    tbl[1] = '{5'd1, 3'd1, 1'b0, 0, 5'd0};
    tbl[2] = '{5'd2, 3'd3, 1'b1, 1, 5'd2};
    tbl[3] = '{5'd3, 3'd3, 1'b0, 1, 5'd2};
    tbl[4] = '{5'd4, 3'd0, 1'b1, 2, 5'd2};
    tbl[5] = '{5'd5, 3'd2, 1'b0, 2, 5'd2};
    tbl[6] = '{5'd6, 3'd3, 1'b0, 2, 5'd2};
    tbl[7] = '{5'd7, 3'd4, 1'b0, 2, 5'd2};
    tbl[8] = '{5'd8, 3'd6, 1'b1, 3, 5'd2};
    tbl[9] = '{5'd9, 3'd3, 1'b0, 3, 5'd2};

    // Reset state
    #12;
    chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0); chk("rst_ff", first_fail, 0); chk("rst_mm", mismatch, 0);
    rst_n = 1'b1;

    // Good sweep
    tick(1'b1, 1'b0, 5'd0);
    chk("good_busy", busy, 1);
    mm_pulses = 0;
    for (int i = 0; i < 31; i++) tick(1'b0, 1'b1, 5'(i));
    chk("good_done_early", done, 0);
    tick(1'b0, 1'b1, 5'd31);
    chk("good_done", done, 1); chk("good_pass", pass, 1); chk("good_busy_end", busy, 0);
    chk("good_err", err_cnt, 0); chk("good_ff", first_fail, 0); chk("good_mm", mm_pulses, 0);
    chk("sat_err", s_err_cnt, 7); chk("sat_pass", s_pass, 0); chk("sat_done", s_done, 1);
    tick(1'b0, 1'b0, 5'd0);
    chk("done_held", done, 1);

    // Table-driven vectors with hand-chosen adder outputs
    tick(1'b1, 1'b0, 5'd0);
    fault_mode = 2;
    for (int i = 0; i < 10; i++) begin
      ovr = tbl[i].drv;
      tick(1'b0, 1'b1, tbl[i].v);
      chk($sformatf("tbl%0d_mm", i), mismatch, tbl[i].exp_mm);
      chk($sformatf("tbl%0d_err", i), err_cnt, tbl[i].exp_err);
      chk($sformatf("tbl%0d_ff", i), first_fail, tbl[i].exp_ff);
    end
    fault_mode = 0;
    run_sweep(10);
    chk("tbl_done", done, 1); chk("tbl_pass", pass, 0);
    chk("tbl_err", err_cnt, 3); chk("tbl_seq", seq_err, 0);

    // Stuck-at S0
    fault_mode = 1;
    tick(1'b1, 1'b0, 5'd0);
    mm_pulses = 0;
    run_sweep(0);
    chk("stuck_err", err_cnt, 16); chk("stuck_ff", first_fail, 5'b00001);
    chk("stuck_pass", pass, 0); chk("stuck_mm", mm_pulses, 16); chk("stuck_done", done, 1);

    // Restart from DONE with start+valid together: vector must be dropped
    fault_mode = 0;
    tick(1'b1, 1'b1, 5'd0);
    chk("restart_err", err_cnt, 0); chk("restart_ff", first_fail, 0);
    chk("restart_done", done, 0); chk("restart_busy", busy, 1);
    for (int i = 0; i < 32; i++) begin
      if (i == 31) begin
        chk("gap_done_early", done, 0); chk("gap_busy", busy, 1);
      end
      tick(1'b0, 1'b1, 5'(i));
      if (i == 5) tick(1'b1, 1'b0, 5'd0);  // start during RUN
      else if (i < 31) tick(1'b0, 1'b0, 5'd0);
    end
    chk("gap_done", done, 1); chk("gap_pass", pass, 1); chk("gap_seq", seq_err, 0);

    // Sequence error: 11 sent in place of 10
    tick(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 5'(i));
    chk("seq_before", seq_err, 0);
    tick(1'b0, 1'b1, 5'd11);
    chk("seq_set", seq_err, 1);
    run_sweep(11);
    chk("seq_done", done, 1); chk("seq_pass", pass, 0);
    chk("seq_sticky", seq_err, 1); chk("seq_err_cnt", err_cnt, 0);

    // Mid-sweep asynchronous reset
    fault_mode = 1;
    tick(1'b1, 1'b0, 5'd0);
    for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 5'(i));
    chk("pre_rst_err", err_cnt, 6);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0); chk("arst_err", err_cnt, 0);
    chk("arst_ff", first_fail, 0); chk("arst_done", done, 0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    mm_pulses = 0;
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 5'(i));
    chk("idle_busy", busy, 0); chk("idle_err", err_cnt, 0);
    chk("idle_mm", mm_pulses, 0); chk("idle_ff", first_fail, 0); chk("idle_seq", seq_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
